// File: rtl/rv64i_instr_encoder.sv
// RV64I instruction encoder: mnemonic-level request in, 32-bit instruction word out.
// Requests are encoded combinationally, then registered into a 2-entry output FIFO.
module rv64i_instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           op_sel,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_illegal,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready depends only on the registered FIFO count, never on out_ready.

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPW    = 7'b0111011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH64 = 3'd6;
  localparam logic [2:0] FMT_SHW  = 3'd7;

  logic [2:0]  fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        op_ok;

  always_comb begin
    fmt   = FMT_R;
    opc   = 7'd0;
    f3    = 3'd0;
    f7    = 7'd0;
    op_ok = 1'b1;
    case (op_sel)
      6'd0:  {fmt, opc, f3} = {FMT_I, OPC_LOAD, 3'd0};
      6'd1:  {fmt, opc, f3} = {FMT_I, OPC_LOAD, 3'd1};
      6'd2:  {fmt, opc, f3} = {FMT_I, OPC_LOAD, 3'd2};
      6'd3:  {fmt, opc, f3} = {FMT_I, OPC_LOAD, 3'd3};
      6'd4:  {fmt, opc, f3} = {FMT_I, OPC_LOAD, 3'd4};
      6'd5:  {fmt, opc, f3} = {FMT_I, OPC_LOAD, 3'd5};
      6'd6:  {fmt, opc, f3} = {FMT_I, OPC_LOAD, 3'd6};
      6'd7:  {fmt, opc, f3} = {FMT_I, OPC_OPIMM, 3'd0};
      6'd8:  {fmt, opc, f3} = {FMT_I, OPC_OPIMM, 3'd2};
      6'd9:  {fmt, opc, f3} = {FMT_I, OPC_OPIMM, 3'd3};
      6'd10: {fmt, opc, f3} = {FMT_I, OPC_OPIMM, 3'd4};
      6'd11: {fmt, opc, f3} = {FMT_I, OPC_OPIMM, 3'd6};
      6'd12: {fmt, opc, f3} = {FMT_I, OPC_OPIMM, 3'd7};
      6'd13: {fmt, opc, f3, f7} = {FMT_SH64, OPC_OPIMM, 3'd1, 7'h00};
      6'd14: {fmt, opc, f3, f7} = {FMT_SH64, OPC_OPIMM, 3'd5, 7'h00};
      6'd15: {fmt, opc, f3, f7} = {FMT_SH64, OPC_OPIMM, 3'd5, 7'h20};
      6'd16: {fmt, opc, f3} = {FMT_I, OPC_OPIMMW, 3'd0};
      6'd17: {fmt, opc, f3, f7} = {FMT_SHW, OPC_OPIMMW, 3'd1, 7'h00};
      6'd18: {fmt, opc, f3, f7} = {FMT_SHW, OPC_OPIMMW, 3'd5, 7'h00};
      6'd19: {fmt, opc, f3, f7} = {FMT_SHW, OPC_OPIMMW, 3'd5, 7'h20};
      6'd20: {fmt, opc, f3, f7} = {FMT_R, OPC_OP, 3'd0, 7'h00};
      6'd21: {fmt, opc, f3, f7} = {FMT_R, OPC_OP, 3'd0, 7'h20};
      6'd22: {fmt, opc, f3, f7} = {FMT_R, OPC_OP, 3'd1, 7'h00};
      6'd23: {fmt, opc, f3, f7} = {FMT_R, OPC_OP, 3'd2, 7'h00};
      6'd24: {fmt, opc, f3, f7} = {FMT_R, OPC_OP, 3'd3, 7'h00};
      6'd25: {fmt, opc, f3, f7} = {FMT_R, OPC_OP, 3'd4, 7'h00};
      6'd26: {fmt, opc, f3, f7} = {FMT_R, OPC_OP, 3'd5, 7'h00};
      6'd27: {fmt, opc, f3, f7} = {FMT_R, OPC_OP, 3'd5, 7'h20};
      6'd28: {fmt, opc, f3, f7} = {FMT_R, OPC_OP, 3'd6, 7'h00};
      6'd29: {fmt, opc, f3, f7} = {FMT_R, OPC_OP, 3'd7, 7'h00};
      6'd30: {fmt, opc, f3} = {FMT_S, OPC_STORE, 3'd0};
      6'd31: {fmt, opc, f3} = {FMT_S, OPC_STORE, 3'd1};
      6'd32: {fmt, opc, f3} = {FMT_S, OPC_STORE, 3'd2};
      6'd33: {fmt, opc, f3} = {FMT_S, OPC_STORE, 3'd3};
      6'd34: {fmt, opc, f3} = {FMT_B, OPC_BRANCH, 3'd0};
      6'd35: {fmt, opc, f3} = {FMT_B, OPC_BRANCH, 3'd1};
      6'd36: {fmt, opc, f3} = {FMT_B, OPC_BRANCH, 3'd4};
      6'd37: {fmt, opc, f3} = {FMT_B, OPC_BRANCH, 3'd5};
      6'd38: {fmt, opc, f3} = {FMT_B, OPC_BRANCH, 3'd6};
      6'd39: {fmt, opc, f3} = {FMT_B, OPC_BRANCH, 3'd7};
      6'd40: {fmt, opc} = {FMT_J, OPC_JAL};
      6'd41: {fmt, opc, f3} = {FMT_I, OPC_JALR, 3'd0};
      6'd42: {fmt, opc, f3, f7} = {FMT_R, OPC_OPW, 3'd0, 7'h00};
      6'd43: {fmt, opc, f3, f7} = {FMT_R, OPC_OPW, 3'd0, 7'h20};
      6'd44: {fmt, opc, f3, f7} = {FMT_R, OPC_OPW, 3'd1, 7'h00};
      6'd45: {fmt, opc, f3, f7} = {FMT_R, OPC_OPW, 3'd5, 7'h00};
      6'd46: {fmt, opc, f3, f7} = {FMT_R, OPC_OPW, 3'd5, 7'h20};
      6'd47: {fmt, opc} = {FMT_U, OPC_LUI};
      6'd48: {fmt, opc} = {FMT_U, OPC_AUIPC};
      default: op_ok = 1'b0;
    endcase
  end

  // Range checks: the immediate must be a sign extension of its encodable field.
  logic fits12, fits13, fits21;
  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  logic        imm_ok;
  logic [31:0] enc_word;

  always_comb begin
    imm_ok   = 1'b1;
    enc_word = '0;
    case (fmt)
      FMT_R:    enc_word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I: begin
        imm_ok   = fits12;
        enc_word = {imm[11:0], rs1, f3, rd, opc};
      end
      FMT_S: begin
        imm_ok   = fits12;
        enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      end
      FMT_B: begin
        imm_ok   = fits13 && !imm[0];
        enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      end
      FMT_U: begin
        imm_ok   = (imm[31:20] == '0);
        enc_word = {imm[19:0], rd, opc};
      end
      FMT_J: begin
        imm_ok   = fits21 && !imm[0];
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      end
      FMT_SH64: begin
        imm_ok   = (imm[31:6] == '0);
        enc_word = {f7[6:1], imm[5:0], rs1, f3, rd, opc};
      end
      default: begin
        imm_ok   = (imm[31:5] == '0);
        enc_word = {f7, imm[4:0], rs1, f3, rd, opc};
      end
    endcase
  end

  logic        enc_illegal;
  logic [32:0] enc_entry;
  assign enc_illegal = !(op_ok && imm_ok);
  assign enc_entry   = enc_illegal ? {1'b1, NOP_WORD} : {1'b0, enc_word};

  // Output FIFO: two slots, {illegal, instr} per entry.
  logic [32:0]          mem0_q, mem0_d, mem1_q, mem1_d;
  logic                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 push, pop;
  logic [32:0]          head;

  assign in_ready  = (32'(count_q) < FIFO_DEPTH);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (push) begin
      if (wr_ptr_q) mem1_d = enc_entry;
      else          mem0_d = enc_entry;
      wr_ptr_d = !wr_ptr_q;
      if (enc_illegal && !(&err_q)) err_d = err_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
    if (pop) rd_ptr_d = !rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      err_q    <= '0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign head        = rd_ptr_q ? mem1_q : mem0_q;
  assign out_instr   = head[31:0];
  assign out_illegal = head[32];
  assign err_count   = err_q;

endmodule

// File: tb/tb_rv64i_instr_encoder.sv
// Bench for rv64i_instr_encoder: directed vector table, FIFO corner sequences and
// randomized requests scored against an arithmetic RV64I encoding model.
module tb_rv64i_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  op_sel = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [7:0]  err_count;

  rv64i_instr_encoder #(.FIFO_DEPTH(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_illegal(out_illegal), .err_count(err_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [32:0] exp_q[$];
  int          exp_err = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", {63'd0, out_valid}, 64'd0);
      else check("out_word", {31'd0, out_illegal, out_instr}, {31'd0, exp_q.pop_front()});
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- reference model ----------------
  localparam int F3_OPIMM [0:8] = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
  localparam int F3_OP    [0:9] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  localparam int F3_BR    [0:5] = '{0, 1, 4, 5, 6, 7};
  localparam int F3_OPW   [0:4] = '{0, 0, 1, 5, 5};

  function automatic logic [31:0] i_fmt(input int top12, input int a, input int f3, input int d, input int opc);
    return 32'((top12 & 'hfff) << 20) | 32'(a << 15) | 32'(f3 << 12) | 32'(d << 7) | 32'(opc);
  endfunction

  function automatic logic [31:0] r_fmt(input int f7, input int b, input int a, input int f3, input int d, input int opc);
    return i_fmt(f7 * 32 + b, a, f3, d, opc);
  endfunction

  function automatic logic [31:0] s_fmt(input int s, input int b, input int a, input int f3);
    return r_fmt((s >>> 5) & 127, b, a, f3, s & 31, 'h23);
  endfunction

  function automatic logic [31:0] b_fmt(input int s, input int b, input int a, input int f3);
    return r_fmt(((s >>> 12) & 1) * 64 + ((s >>> 5) & 63), b, a, f3,
                 ((s >>> 1) & 15) * 2 + ((s >>> 11) & 1), 'h63);
  endfunction

  function automatic logic [31:0] j_fmt(input int s, input int d);
    int v;
    v = (((s >>> 20) & 1) << 19) | (((s >>> 1) & 1023) << 9) | (((s >>> 11) & 1) << 8) | ((s >>> 12) & 255);
    return 32'(v << 12) | 32'(d << 7) | 32'h6f;
  endfunction

  function automatic logic [32:0] ref_enc(input int op, input int d, input int a, input int b, input logic [31:0] im);
    int s;
    bit ok;
    bit in12;
    logic [31:0] w;
    s = $signed(im);
    in12 = (s >= -2048) && (s <= 2047);
    ok = 1'b1;
    w = '0;
    if (op <= 6) begin
      ok = in12; w = i_fmt(s, a, op, d, 'h03);
    end else if (op <= 12) begin
      ok = in12; w = i_fmt(s, a, F3_OPIMM[op-7], d, 'h13);
    end else if (op <= 15) begin
      ok = (s >= 0) && (s <= 63); w = i_fmt(((op == 15) ? 16 : 0) * 64 + s, a, F3_OPIMM[op-7], d, 'h13);
    end else if (op == 16) begin
      ok = in12; w = i_fmt(s, a, 0, d, 'h1b);
    end else if (op <= 19) begin
      ok = (s >= 0) && (s <= 31); w = i_fmt(((op == 19) ? 32 : 0) * 32 + s, a, (op == 17) ? 1 : 5, d, 'h1b);
    end else if (op <= 29) begin
      w = r_fmt((op == 21 || op == 27) ? 32 : 0, b, a, F3_OP[op-20], d, 'h33);
    end else if (op <= 33) begin
      ok = in12; w = s_fmt(s, b, a, op - 30);
    end else if (op <= 39) begin
      ok = (s >= -4096) && (s <= 4094) && ((s & 1) == 0); w = b_fmt(s, b, a, F3_BR[op-34]);
    end else if (op == 40) begin
      ok = (s >= -1048576) && (s <= 1048574) && ((s & 1) == 0); w = j_fmt(s, d);
    end else if (op == 41) begin
      ok = in12; w = i_fmt(s, a, 0, d, 'h67);
    end else if (op <= 46) begin
      w = r_fmt((op == 43 || op == 46) ? 32 : 0, b, a, F3_OPW[op-42], d, 'h3b);
    end else if (op <= 48) begin
      ok = (im < 32'h0010_0000);
      w = ((im & 32'h000f_ffff) << 12) | 32'(d << 7) | ((op == 47) ? 32'h37 : 32'h17);
    end else begin
      ok = 1'b0;
    end
    return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
  endfunction

  function automatic logic [31:0] rand_imm();
    int v;
    case ($urandom_range(0, 4))
      0: v = int'($urandom_range(0, 70));
      1: v = int'($urandom_range(0, 8400)) - 4200;
      2: v = int'($urandom_range(0, 3145728)) - 1572864;
      3: v = int'($urandom_range(0, 1310720));
      default: v = int'($urandom());
    endcase
    return 32'(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int op, input int d, input int a, input int b, input logic [31:0] im,
                      input logic [32:0] expw);
    int guard;
    op_sel = 6'(op); rd = 5'(d); rs1 = 5'(a); rs2 = 5'(b); imm = im;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(expw);
    if (expw[32] && exp_err < 255) exp_err++;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_m(input int op, input int d, input int a, input int b, input logic [31:0] im);
    send(op, d, a, b, im, ref_enc(op, d, a, b, im));
  endtask

  task automatic drain();
    int guard;
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      step();
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    step();
    check("idle_after_drain", {63'd0, out_valid}, 64'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          op;
    int          rd;
    int          rs1;
    int          rs2;
    logic [31:0] imm;
    logic [32:0] exp;
  } vec_t;

  localparam logic [32:0] ILL = {1'b1, 32'h0000_0013};
  vec_t vecs [0:25];

  initial begin
    vecs[0]  = '{7, 2, 1, 0, 32'd2048, ILL};
    vecs[1]  = '{34, 0, 1, 2, 32'd5, ILL};
    vecs[2]  = '{55, 2, 1, 2, 32'd0, ILL};
    vecs[3]  = '{21, 3, 1, 2, 32'd0, {1'b0, 32'h402081B3}};
    vecs[4]  = '{34, 0, 1, 2, 32'd8, {1'b0, 32'h00208463}};
    vecs[5]  = '{40, 1, 0, 0, 32'd2048, {1'b0, 32'h001000EF}};
    vecs[6]  = '{15, 2, 1, 0, 32'd63, {1'b0, 32'h43F0D113}};
    vecs[7]  = '{47, 2, 0, 0, 32'h100, {1'b0, 32'h00100137}};
    vecs[8]  = '{19, 2, 1, 0, 32'd32, ILL};
    vecs[9]  = '{7, 2, 1, 0, 32'hFFFFF800, {1'b0, 32'h80008113}};
    vecs[10] = '{34, 0, 1, 2, 32'd4094, {1'b0, 32'h7E208FE3}};
    vecs[11] = '{36, 0, 1, 2, 32'hFFFFF000, {1'b0, 32'h8020C063}};
    vecs[12] = '{40, 1, 0, 0, 32'hFFF00000, {1'b0, 32'h800000EF}};
    vecs[13] = '{40, 1, 0, 0, 32'h00100000, ILL};
    vecs[14] = '{13, 2, 1, 0, 32'd64, ILL};
    vecs[15] = '{47, 2, 0, 0, 32'h00100000, ILL};
    vecs[16] = '{32, 0, 1, 2, 32'hFFFFFFFF, {1'b0, 32'hFE20AFA3}};
    vecs[17] = '{17, 2, 1, 0, 32'd31, {1'b0, 32'h01F0911B}};
    vecs[18] = '{28, 5, 6, 7, 32'd0, {1'b0, 32'h007362B3}};
    vecs[19] = '{14, 2, 1, 0, 32'd63, {1'b0, 32'h03F0D113}};
    vecs[20] = '{41, 1, 2, 0, 32'hFFFFFFFC, {1'b0, 32'hFFC100E7}};
    vecs[21] = '{19, 2, 1, 0, 32'd31, {1'b0, 32'h41F0D11B}};
    vecs[22] = '{48, 3, 0, 0, 32'h000FFFFF, {1'b0, 32'hFFFFF197}};
    vecs[23] = '{3, 4, 5, 0, 32'd16, {1'b0, 32'h0102B203}};
    vecs[24] = '{49, 1, 1, 1, 32'd0, ILL};
    vecs[25] = '{63, 1, 1, 1, 32'd0, ILL};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_instr", {32'd0, out_instr}, 64'd0);
    check("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
    check("rst_err_count", {56'd0, err_count}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    step();

    // first transaction and its latency
    out_ready = 1'b1;
    send(7, 2, 1, 0, 32'd1, {1'b0, 32'h00108113});
    check("latency_out_valid", {63'd0, out_valid}, 64'd1);
    drain();

    // illegal sweep, then the rest of the table
    for (int i = 0; i < 3; i++) send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].exp);
    drain();
    check("err_after_sweep", {56'd0, err_count}, 64'd3);
    for (int i = 3; i < 26; i++) send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].exp);
    drain();
    check("err_after_table", {56'd0, err_count}, 64'(exp_err));

    // backpressure: two fill the FIFO, the third waits for the first pop
    out_ready = 1'b0;
    send(7, 10, 11, 0, 32'd100, {1'b0, 32'h0645_8513});
    send(7, 12, 13, 0, 32'd200, {1'b0, 32'h0C86_8613});
    check("full_head", {31'd0, out_illegal, out_instr}, {31'd0, 1'b0, 32'h0645_8513});
    op_sel = 6'd20; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; imm = '0;
    in_valid = 1'b1;
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    check("full_in_ready_hold", {63'd0, in_ready}, 64'd0);
    check("stall_head_hold", {32'd0, out_instr}, {32'd0, 32'h0645_8513});
    out_ready = 1'b1;
    check("full_no_comb_ready", {63'd0, in_ready}, 64'd0);
    step();
    check("ready_after_pop", {63'd0, in_ready}, 64'd1);
    exp_q.push_back({1'b0, 32'h0031_00B3});
    step();
    in_valid = 1'b0;
    drain();

    // saturation of the illegal counter
    for (int i = 0; i < 300; i++) begin
      case (i % 5)
        0: send_m(7, 1, 2, 3, 32'd5000);
        1: send_m(34, 1, 2, 3, 32'd3);
        2: send_m(49 + (i % 15), 1, 2, 3, 32'd0);
        3: send_m(13, 1, 2, 3, 32'd64);
        default: send_m(47, 1, 2, 3, 32'hFFFF_FFFF);
      endcase
    end
    drain();
    check("err_saturated", {56'd0, err_count}, 64'd255);

    // asynchronous reset with a full FIFO
    out_ready = 1'b0;
    send(7, 2, 1, 0, 32'd7, {1'b0, 32'h0070_8113});
    send(7, 2, 1, 0, 32'd8, {1'b0, 32'h0080_8113});
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_err_count", {56'd0, err_count}, 64'd0);
    check("async_rst_out_instr", {32'd0, out_instr}, 64'd0);
    check("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    exp_err = 0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    send(7, 2, 1, 0, 32'd1, {1'b0, 32'h00108113});
    drain();
    check("err_after_reset", {56'd0, err_count}, 64'd0);

    // randomized requests with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      send_m(int'($urandom_range(0, 63)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), rand_imm());
    end
    drain();
    check("err_after_random", {56'd0, err_count}, 64'(exp_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
